// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronises the board reset, holds downstream resets for
// 2^HOLD_BITS cycles, then releases CHANNELS active-high resets in index order
// with STAGGER cycles between releases. Also provides a software reset request,
// a kickable watchdog, and a latched reset-cause register.
//
// Ports:
//   CLK       system clock
//   resetn    asynchronous active-low board/POR reset
//   sw_req    software reset request (single-cycle pulse, honoured in RUN only)
//   wdt_en    watchdog enable (level)
//   wdt_kick  watchdog restart (single-cycle pulse)
//   rst_out   active-high resets to downstream blocks, channel 0 released first
//   busy      high while the sequencer is not in RUN
//   cause     last reset source: 01 POR, 10 SW, 11 WDT
module reset_sequencer #(
    parameter int unsigned CHANNELS    = 2,   // >= 1
    parameter int unsigned HOLD_BITS   = 5,
    parameter int unsigned STAGGER     = 4,   // >= 1
    parameter int unsigned SYNC_STAGES = 2,   // >= 2
    parameter int unsigned WDT_BITS    = 16
) (
    input  logic                CLK,
    input  logic                resetn,
    input  logic                sw_req,
    input  logic                wdt_en,
    input  logic                wdt_kick,
    output logic [CHANNELS-1:0] rst_out,
    output logic                busy,
    output logic [1:0]          cause
);

    localparam int unsigned IDX_W = $clog2(CHANNELS + 1);
    localparam int unsigned STG_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    localparam logic [HOLD_BITS-1:0] HOLD_MAX = '1;
    localparam logic [WDT_BITS-1:0]  WDT_MAX  = '1;
    localparam logic [STG_W-1:0]     STG_LAST = STG_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(CHANNELS - 1);

    localparam logic [1:0] CAUSE_POR = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [HOLD_BITS-1:0]  hold_q, hold_d;
    logic [STG_W-1:0]      stg_q, stg_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WDT_BITS-1:0]   wdt_q, wdt_d;
    logic [CHANNELS-1:0]   rst_out_d;
    logic                  busy_d;
    logic [1:0]            cause_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_n;

    logic sw_evt;
    logic wdt_exp;
    logic restart;
    logic hold_done;
    logic stg_done;
    logic last_rel;

    // Reset-deassert synchroniser: clears asynchronously, releases after SYNC_STAGES edges
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_n = sync_q[SYNC_STAGES-1];

    // Restart events; software request wins over watchdog expiry, a kick suppresses expiry
    assign sw_evt    = (state_q == ST_RUN) && sw_req;
    assign wdt_exp   = (state_q == ST_RUN) && wdt_en && !wdt_kick && (wdt_q == WDT_MAX);
    assign restart   = sw_evt || wdt_exp;

    assign hold_done = (state_q == ST_HOLD) && sync_n && (hold_q == HOLD_MAX);
    assign stg_done  = (state_q == ST_RELEASE) && (stg_q == STG_LAST);
    assign last_rel  = stg_done && (idx_q == IDX_LAST);

    // State and registered outputs
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            stg_q   <= '0;
            idx_q   <= '0;
            wdt_q   <= '0;
            rst_out <= '1;
            busy    <= 1'b1;
            cause   <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stg_q   <= stg_d;
            idx_q   <= idx_d;
            wdt_q   <= wdt_d;
            rst_out <= rst_out_d;
            busy    <= busy_d;
            cause   <= cause_d;
        end
    end

    // Next state and counters
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stg_d   = stg_q;
        idx_d   = idx_q;
        wdt_d   = '0;
        unique case (state_q)
            ST_HOLD: begin
                if (hold_done) begin
                    // Channel 0 goes out on this edge; a single channel means we are done
                    state_d = (CHANNELS == 1) ? ST_RUN : ST_RELEASE;
                    hold_d  = '0;
                    stg_d   = '0;
                    idx_d   = IDX_W'(1);
                end else if (sync_n) begin
                    hold_d = hold_q + HOLD_BITS'(1);
                end
            end
            ST_RELEASE: begin
                if (stg_done) begin
                    stg_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (last_rel) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    stg_d = stg_q + STG_W'(1);
                end
            end
            ST_RUN: begin
                if (restart) begin
                    // Synchroniser stays high, so the hold period restarts immediately
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end else if (wdt_en && !wdt_kick) begin
                    wdt_d = wdt_q + WDT_BITS'(1);
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        rst_out_d = rst_out;
        busy_d    = busy;
        cause_d   = cause;
        if (restart) begin
            rst_out_d = '1;
            busy_d    = 1'b1;
            cause_d   = sw_evt ? CAUSE_SW : CAUSE_WDT;
        end else if (hold_done) begin
            rst_out_d[0] = 1'b0;
            if (CHANNELS == 1) begin
                busy_d = 1'b0;
            end
        end else if (stg_done) begin
            // Only the indexed channel is released, keeping release order monotonic
            for (int i = 0; i < CHANNELS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    rst_out_d[i] = 1'b0;
                end
            end
            if (last_rel) begin
                busy_d = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: POR timing across several parameter sets,
// software reset, watchdog expiry/kick behaviour, priorities and async reset.
module tb_reset_sequencer;

    localparam int SYNC = 2;

    logic CLK = 1'b0;
    logic resetn = 1'b0;
    logic idle = 1'b0;

    logic sw_req0 = 1'b0;
    logic wdt_en0 = 1'b0;
    logic wdt_kick0 = 1'b0;
    logic [1:0] rst0;
    logic busy0;
    logic [1:0] cause0;

    logic sw_req_w = 1'b0;
    logic wdt_en_w = 1'b0;
    logic wdt_kick_w = 1'b0;
    logic [1:0] rstw;
    logic busyw;
    logic [1:0] causew;

    logic [0:0] rst_c1;
    logic busy_c1;
    logic [1:0] cause_c1;
    logic [3:0] rst_c4;
    logic busy_c4;
    logic [1:0] cause_c4;
    logic [1:0] rst_h3;
    logic busy_h3;
    logic [1:0] cause_h3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    reset_sequencer dut0 (
        .CLK(CLK), .resetn(resetn), .sw_req(sw_req0), .wdt_en(wdt_en0), .wdt_kick(wdt_kick0),
        .rst_out(rst0), .busy(busy0), .cause(cause0)
    );

    reset_sequencer #(.WDT_BITS(4)) dut_w (
        .CLK(CLK), .resetn(resetn), .sw_req(sw_req_w), .wdt_en(wdt_en_w), .wdt_kick(wdt_kick_w),
        .rst_out(rstw), .busy(busyw), .cause(causew)
    );

    reset_sequencer #(.CHANNELS(1)) dut_c1 (
        .CLK(CLK), .resetn(resetn), .sw_req(idle), .wdt_en(idle), .wdt_kick(idle),
        .rst_out(rst_c1), .busy(busy_c1), .cause(cause_c1)
    );

    reset_sequencer #(.CHANNELS(4), .STAGGER(1)) dut_c4 (
        .CLK(CLK), .resetn(resetn), .sw_req(idle), .wdt_en(idle), .wdt_kick(idle),
        .rst_out(rst_c4), .busy(busy_c4), .cause(cause_c4)
    );

    reset_sequencer #(.HOLD_BITS(3)) dut_h3 (
        .CLK(CLK), .resetn(resetn), .sw_req(idle), .wdt_en(idle), .wdt_kick(idle),
        .rst_out(rst_h3), .busy(busy_h3), .cause(cause_h3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Channel i is still held at POR edge n while n < SYNC + 2^hb + i*stg
    function automatic logic [31:0] exp_rst(int n, int ch, int hb, int stg);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < ch; i++) begin
            if (n < SYNC + (1 << hb) + i * stg) r = r | (32'd1 << i);
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_busy(int n, int ch, int hb, int stg);
        return (n < SYNC + (1 << hb) + (ch - 1) * stg) ? 32'd1 : 32'd0;
    endfunction

    // Count POR edges from the first edge that samples resetn high
    task automatic por_count(input string ph);
        for (int n = 1; n <= 45; n++) begin
            @(posedge CLK); #1;
            check($sformatf("%s rst0 e%0d", ph, n), 32'(rst0), exp_rst(n, 2, 5, 4));
            check($sformatf("%s busy0 e%0d", ph, n), 32'(busy0), exp_busy(n, 2, 5, 4));
            check($sformatf("%s rstw e%0d", ph, n), 32'(rstw), exp_rst(n, 2, 5, 4));
            check($sformatf("%s rst_c1 e%0d", ph, n), 32'(rst_c1), exp_rst(n, 1, 5, 4));
            check($sformatf("%s busy_c1 e%0d", ph, n), 32'(busy_c1), exp_busy(n, 1, 5, 4));
            check($sformatf("%s rst_c4 e%0d", ph, n), 32'(rst_c4), exp_rst(n, 4, 5, 1));
            check($sformatf("%s busy_c4 e%0d", ph, n), 32'(busy_c4), exp_busy(n, 4, 5, 1));
            check($sformatf("%s rst_h3 e%0d", ph, n), 32'(rst_h3), exp_rst(n, 2, 3, 4));
            check($sformatf("%s busy_h3 e%0d", ph, n), 32'(busy_h3), exp_busy(n, 2, 3, 4));
        end
        check({ph, " cause0"}, 32'(cause0), 32'd1);
        check({ph, " causew"}, 32'(causew), 32'd1);
        check({ph, " cause_c4"}, 32'(cause_c4), 32'd1);
    endtask

    // Watchdog DUT sequence after a restart asserted at relative edge 16
    task automatic wdt_recover(input string ph, input logic [31:0] exp_cause);
        for (int k = 17; k <= 52; k++) begin
            @(posedge CLK); #1;
            check($sformatf("%s rstw k%0d", ph, k), 32'(rstw), (k < 48) ? 32'd3 : (k < 52) ? 32'd2 : 32'd0);
            check($sformatf("%s busyw k%0d", ph, k), 32'(busyw), (k < 52) ? 32'd1 : 32'd0);
        end
        check({ph, " causew"}, 32'(causew), exp_cause);
    endtask

    initial begin
        // Power-on reset
        resetn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst rst0", 32'(rst0), 32'd3);
        check("rst busy0", 32'(busy0), 32'd1);
        check("rst cause0", 32'(cause0), 32'd1);
        check("rst rst_c4", 32'(rst_c4), 32'hf);
        check("rst rst_c1", 32'(rst_c1), 32'd1);
        resetn = 1'b1;
        por_count("por");

        // Software reset, with ignored requests during HOLD and RELEASE
        sw_req0 = 1'b1;
        @(posedge CLK); #1;
        sw_req0 = 1'b0;
        check("sw rst0 k0", 32'(rst0), 32'd3);
        check("sw busy0 k0", 32'(busy0), 32'd1);
        check("sw cause0 k0", 32'(cause0), 32'd2);
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK); #1;
            check($sformatf("sw rst0 k%0d", k), 32'(rst0), (k < 32) ? 32'd3 : (k < 36) ? 32'd2 : 32'd0);
            check($sformatf("sw busy0 k%0d", k), 32'(busy0), (k < 36) ? 32'd1 : 32'd0);
            check($sformatf("sw cause0 k%0d", k), 32'(cause0), 32'd2);
            sw_req0 = (k == 10) || (k == 33);
        end
        sw_req0 = 1'b0;

        // Watchdog expiry without kicks
        wdt_en_w = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge CLK); #1;
            check($sformatf("wdt rstw k%0d", k), 32'(rstw), (k < 16) ? 32'd0 : 32'd3);
            check($sformatf("wdt busyw k%0d", k), 32'(busyw), (k < 16) ? 32'd0 : 32'd1);
        end
        check("wdt causew", 32'(causew), 32'd3);
        wdt_en_w = 1'b0;
        wdt_recover("wdt", 32'd3);

        // Regular kicks keep the watchdog from expiring
        wdt_en_w = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge CLK); #1;
            check($sformatf("kick rstw k%0d", k), 32'(rstw), 32'd0);
            check($sformatf("kick busyw k%0d", k), 32'(busyw), 32'd0);
            wdt_kick_w = (k % 10 == 0);
        end
        wdt_kick_w = 1'b0;
        wdt_en_w = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Kick on the very edge the count sits at its maximum
        wdt_en_w = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK); #1;
            check($sformatf("edgekick rstw k%0d", k), 32'(rstw), 32'd0);
            check($sformatf("edgekick busyw k%0d", k), 32'(busyw), 32'd0);
            wdt_kick_w = (k == 15);
        end
        wdt_kick_w = 1'b0;
        wdt_en_w = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Software request and watchdog expiry on the same edge
        wdt_en_w = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge CLK); #1;
            check($sformatf("prio rstw k%0d", k), 32'(rstw), 32'd0);
        end
        sw_req_w = 1'b1;
        @(posedge CLK); #1;
        sw_req_w = 1'b0;
        wdt_en_w = 1'b0;
        check("prio rstw k16", 32'(rstw), 32'd3);
        check("prio busyw k16", 32'(busyw), 32'd1);
        check("prio causew k16", 32'(causew), 32'd2);
        wdt_recover("prio", 32'd2);

        // Async reset glitch between edges while dut0 is in RELEASE
        sw_req0 = 1'b1;
        @(posedge CLK); #1;
        sw_req0 = 1'b0;
        repeat (34) @(posedge CLK);
        #1;
        check("glitch pre rst0", 32'(rst0), 32'd2);
        check("glitch pre cause0", 32'(cause0), 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        check("glitch rst0", 32'(rst0), 32'd3);
        check("glitch busy0", 32'(busy0), 32'd1);
        check("glitch cause0", 32'(cause0), 32'd1);
        check("glitch rstw", 32'(rstw), 32'd3);
        check("glitch busyw", 32'(busyw), 32'd1);
        check("glitch causew", 32'(causew), 32'd1);
        check("glitch rst_c4", 32'(rst_c4), 32'hf);
        resetn = 1'b1;
        por_count("repor");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset controller that replaces the fixed 5-bit power-on counter at the FPGA top level. It synchronises the asynchronous active-low board reset, holds all downstream resets for a programmable period, and releases CHANNELS active-high reset outputs in a staggered order (e.g. memory/peripherals before CPU). It adds software-requested reset, a kickable watchdog, and a latched reset-cause register that the SoC can read.

## Interface

- CHANNELS, 2: number of reset outputs, at least 1; channel 0 releases first.
- HOLD_BITS, 5: hold counter width; hold period is 2^HOLD_BITS cycles.
- STAGGER, 4: cycles between consecutive channel releases, at least 1.
- SYNC_STAGES, 2: reset-deassert synchroniser depth, at least 2.
- WDT_BITS, 16: watchdog counter width; timeout is 2^WDT_BITS-1 cycles.

- CLK  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset (board/POR).
- sw_req  in  1  software reset request, single-cycle pulse, synchronous to CLK.
- wdt_en  in  1  watchdog enable, level.
- wdt_kick  in  1  watchdog restart, single-cycle pulse.
- rst_out  out  CHANNELS  active-high resets to downstream blocks.
- busy  out  1  high while not in RUN.
- cause  out  2  last reset source: 01 POR, 10 SW, 11 WDT; 00 is never driven.

## Operation

- Reset is applied asynchronously: resetn low forces rst_out all-ones, busy=1, cause=01, state HOLD, all counters 0, synchroniser chain 0, with no clock required.
- Reset release is synchronous: resetn is passed through SYNC_STAGES flops with async clear; the internal sync_n signal goes high SYNC_STAGES edges after resetn rises.
- States:
  - HOLD: the hold counter increments each edge while sync_n=1. On the edge where it equals 2^HOLD_BITS-1, the FSM enters RELEASE, clears rst_out[0], sets the channel index to 1 and the stagger counter to 0.
  - RELEASE: the stagger counter increments each edge. When it equals STAGGER-1, rst_out[index] is cleared, the index is incremented and the stagger counter returns to 0. When the last channel is cleared, the FSM enters RUN on the same edge. With CHANNELS=1 the FSM passes HOLD → RUN directly, and rst_out[0] clears on that edge.
  - RUN: busy=0 and the watchdog is active.
- Software reset: sw_req=1 in RUN → next edge: rst_out all-ones, busy=1, cause=10, hold counter 0, state HOLD. The sequence then repeats without resynchronisation, because sync_n is already high. sw_req is ignored in HOLD and RELEASE.
- Watchdog: its counter is held at 0 when not in RUN or when wdt_en=0.
  - In RUN with wdt_en=1, wdt_kick=1 clears it; otherwise it increments.
  - On the edge where it equals 2^WDT_BITS-1 with no kick: same effect as a software reset, but cause=11.
- Priority on the same edge:
  - resetn low beats everything else.
  - sw_req beats watchdog expiry (cause=10).
  - wdt_kick beats expiry (no reset).
- rst_out bits are released monotonically in index order. Once set, a channel is never cleared out of order.
- cause holds its value until the next reset event.

## Timing

- All outputs are registered.
- Reset values: rst_out all-ones, busy 1, cause 01.
- POR latency: rst_out[i] falls on edge SYNC_STAGES + 2^HOLD_BITS + i·STAGGER. Edges are counted from the first CLK edge that samples resetn high, which is edge 1. With defaults, rst_out[0] falls at edge 34 and rst_out[1] at edge 38.
- busy falls on the same edge as the last channel release.
- SW/WDT latency: rst_out goes all-ones 1 edge after the request. rst_out[0] falls 2^HOLD_BITS edges after that assertion edge (32 with defaults).
- resetn asserted mid-HOLD, mid-RELEASE or in RUN: outputs return to reset values immediately, and the full POR sequence is rerun.
- A resetn glitch shorter than one cycle still fully resets the block (async clear).

## Test plan

- POR with defaults: release resetn, then count edges → rst_out=11 until edge 34, 10 from edge 34, 00 from edge 38, busy falls at edge 38, cause=01.
- Software reset in RUN: pulse sw_req → next edge rst_out=11, busy=1, cause=10. rst_out[0] clears 32 edges later, rst_out[1] 4 edges after that. sw_req pulsed during RELEASE has no effect.
- Watchdog with WDT_BITS=4: wdt_en=1 and no kicks → reset after 15 cycles in RUN, cause=11. Kicking every 10 cycles → no reset over 200 cycles. Kick coincident with the count reaching 15 → no reset.
- Priority: sw_req and watchdog expiry on the same edge → cause=10. Lower resetn during RELEASE → rst_out immediately all-ones and cause=01, asynchronously, checked between clock edges.
- Parameter sweep: CHANNELS=1, CHANNELS=4 with STAGGER=1, and HOLD_BITS=3 → release edges match SYNC_STAGES + 2^HOLD_BITS + i·STAGGER, and the ordering is monotonic.
